muxn_rr: RTL

Parametrised N-to-1 registered multiplexer that generalises the lab 2:1 mux to N channels of WIDTH bits, with a valid/ready handshake on the output side. It runs in one of two modes: manual select, where an external select picks the source, or round-robin arbitration across all valid channels. It sits between multiple producers and a single consumer, registers the chosen word, and acknowledges the consumed channel.

---
 rtl/muxn_rr.sv | 111 +++++++++++
 1 files changed

// File: rtl/muxn_rr.sv
// muxn_rr: N-to-1 registered mux, manual select or round-robin arbitration.
// Latency: 1 cycle from in_ack to out_valid/out_data. Stalls (in_ack=0) while out_valid && !out_ready.
// Optional feature macro: MUXN_CHAN_EN adds the registered out_chan source-index port.
module muxn_rr #(
  parameter  int WIDTH = 4,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ack,
  input  logic [SELW-1:0]    sel,
  input  logic               mode,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready
`ifdef MUXN_CHAN_EN
  ,
  output logic [SELW-1:0]    out_chan
`endif
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic [SELW-1:0]  r_ptr;

  logic             w_load_en;
  logic [N-1:0]     w_grant;
  logic             w_any;
  logic [SELW-1:0]  w_gidx;
  logic [WIDTH-1:0] w_sel_data;

  // The output slot can take a word when it is empty or being drained this cycle.
  assign w_load_en = !r_valid || out_ready;

  // Grant selection: manual picks sel if valid; round-robin scans upward from ptr+1.
  always_comb begin
    int idx;
    idx     = 0;
    w_grant = '0;
    w_any   = 1'b0;
    w_gidx  = '0;
    if (!mode) begin
      // Comparing against every legal index means sel >= N simply matches nothing.
      for (int i = 0; i < N; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          w_any      = 1'b1;
          w_grant[i] = 1'b1;
          w_gidx     = SELW'(i);
        end
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = (int'(r_ptr) + k) % N;
        if (!w_any && in_valid[idx]) begin
          w_any        = 1'b1;
          w_grant[idx] = 1'b1;
          w_gidx       = SELW'(idx);
        end
      end
    end
  end

  // Word of the granted channel.
  always_comb begin
    w_sel_data = in_data[int'(w_gidx)*WIDTH +: WIDTH];
  end

  // Ack only when the word is really captured; forced low while reset is held.
  assign in_ack = (rst_n && w_load_en) ? w_grant : '0;

  // Output register and round-robin pointer; pointer moves only on a loaded mode-1 grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ptr   <= SELW'(N - 1);
    end else if (w_load_en) begin
      if (w_any) begin
        r_data  <= w_sel_data;
        r_valid <= 1'b1;
        if (mode) begin
          r_ptr <= w_gidx;
        end
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef MUXN_CHAN_EN
  logic [SELW-1:0] r_chan;

  // Source index travels with the data word; holds on stall or empty load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chan <= '0;
    end else if (w_load_en && w_any) begin
      r_chan <= w_gidx;
    end
  end

  assign out_chan = r_chan;
`endif

  assign out_data  = r_data;
  assign out_valid = r_valid;

endmodule
